// File: rtl/led_btn_pkg.sv
// Shared definitions for the LED/button AXI4-Lite register block:
// register offsets, response code, channel FSM state types and strobe helpers.
package led_btn_pkg;

  localparam logic [3:0] LED_OUT_OFS   = 4'h0;
  localparam logic [3:0] BTN_STATE_OFS = 4'h4;
  localparam logic [3:0] BTN_EDGE_OFS  = 4'h8;
  localparam logic [3:0] SCRATCH_OFS   = 4'hC;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Merge write data into an old register value, byte lane by byte lane.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  // Mask with the n least-significant bits set (n in 0..32).
  function automatic logic [31:0] lsb_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/led_btn_debounce.sv
// One push button: 2-flop synchroniser followed by a stability counter.
// level_o changes only after the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; rise_o pulses with a 0->1 change of level_o.
module led_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, count disagreement cycles, flip the level at terminal count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      rise_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= ~level_q;
        rise_q  <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/led_btn_axil_regs.sv
// AXI4-Lite slave with four registers: LED_OUT (RW), BTN_STATE (RO),
// BTN_EDGE (W1C sticky rising edges), SCRATCH_IRQEN (RW).
// Optional interrupt output irq_o is built when LED_BTN_IRQ_EN is defined.
module led_btn_axil_regs
  import led_btn_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_LEDS           = 4,
  parameter int NUM_BTNS           = 4,
  parameter int DEBOUNCE_CYCLES    = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_LEDS-1:0]             led_o,
  input  logic [NUM_BTNS-1:0]             btn_i
`ifdef LED_BTN_IRQ_EN
  ,
  output logic                            irq_o
`endif
);

  localparam logic [31:0] LED_MASK = lsb_mask(NUM_LEDS);
  localparam logic [31:0] BTN_MASK = lsb_mask(NUM_BTNS);

  wr_state_t     wr_state_q;
  rd_state_t     rd_state_q;
  logic          awready_q, wready_q, bvalid_q;
  logic          arready_q, rvalid_q;
  logic [31:0]   rdata_q;
  logic [31:0]   led_q, led_d;
  logic [31:0]   edge_q, edge_d, edge_clr;
  logic [31:0]   scratch_q, scratch_d;
  logic [31:0]   lvl_full, rise_full, rd_mux;
  logic [NUM_BTNS-1:0] btn_lvl, btn_rise;
  logic          wr_hs, rd_hs;

  // Address low bits and protection are don't-care for this block.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_deb
    led_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i   (ACLK),
      .rst_ni  (ARESETN),
      .btn_i   (btn_i[g]),
      .level_o (btn_lvl[g]),
      .rise_o  (btn_rise[g])
    );
  end

  assign wr_hs = awready_q & wready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs = arready_q & S_AXI_ARVALID;

  // Write channel: accept address and data together, then hold the response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (wr_hs) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            wr_state_q <= W_RESP;
          end else begin
            awready_q <= S_AXI_AWVALID & S_AXI_WVALID;
            wready_q  <= S_AXI_AWVALID & S_AXI_WVALID;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Next register values; a new debounced edge overrides a same-cycle W1C.
  always_comb begin
    lvl_full  = '0;
    lvl_full[NUM_BTNS-1:0] = btn_lvl;
    rise_full = '0;
    rise_full[NUM_BTNS-1:0] = btn_rise;
    led_d     = led_q;
    scratch_d = scratch_q;
    edge_clr  = '0;
    if (wr_hs) begin
      case (S_AXI_AWADDR[3:2])
        LED_OUT_OFS[3:2]:  led_d     = apply_strb(led_q, S_AXI_WDATA, S_AXI_WSTRB) & LED_MASK;
        BTN_EDGE_OFS[3:2]: edge_clr  = apply_strb('0, S_AXI_WDATA, S_AXI_WSTRB);
        SCRATCH_OFS[3:2]:  scratch_d = apply_strb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
        default: ;
      endcase
    end
    edge_d = ((edge_q & ~edge_clr) | rise_full) & BTN_MASK;
  end

  // Register file storage.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      led_q     <= '0;
      edge_q    <= '0;
      scratch_q <= '0;
    end else begin
      led_q     <= led_d;
      edge_q    <= edge_d;
      scratch_q <= scratch_d;
    end
  end

  // Read data select; registers hold their pre-write value during a same-cycle write.
  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      LED_OUT_OFS[3:2]:   rd_mux = led_q;
      BTN_STATE_OFS[3:2]: rd_mux = lvl_full;
      BTN_EDGE_OFS[3:2]:  rd_mux = edge_q;
      SCRATCH_OFS[3:2]:   rd_mux = scratch_q;
      default:            rd_mux = '0;
    endcase
  end

  // Read channel: capture data on the address handshake, hold until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (rd_hs) begin
            arready_q  <= 1'b0;
            rdata_q    <= rd_mux;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_DATA;
          end else begin
            arready_q <= S_AXI_ARVALID;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

`ifdef LED_BTN_IRQ_EN
  logic irq_q;

  // Level interrupt: any captured edge whose enable bit is set.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) irq_q <= 1'b0;
    else          irq_q <= |(edge_q[NUM_BTNS-1:0] & scratch_q[NUM_BTNS-1:0]);
  end

  assign irq_o = irq_q;
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign led_o         = led_q[NUM_LEDS-1:0];

endmodule

// File: tb/tb_led_btn_axil_regs.sv
// Self-checking bench for led_btn_axil_regs (default parameters).
// Define LED_BTN_IRQ_EN for both bench and RTL to exercise irq_o.
module tb_led_btn_axil_regs;
  import led_btn_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [3:0]  led_o;
  logic [3:0]  btn_i = '0;
`ifdef LED_BTN_IRQ_EN
  logic        irq_o;
`endif

  led_btn_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
    .NUM_LEDS(4), .NUM_BTNS(4), .DEBOUNCE_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .led_o(led_o), .btn_i(btn_i)
`ifdef LED_BTN_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t exp_b_q[$];
  sb_t exp_r_q[$];

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [3:0]  led;
    string       name;
  } vec_t;
  vec_t vecs[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no handshake within 20 cycles, want one", name);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_aw(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout(name);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
  endtask

  task automatic wait_ar(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout(name);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic collect_b();
    sb_t e;
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin ok = 1'b1; break; end
    end
    e = exp_b_q.pop_front();
    if (!ok) fail_timeout(e.name);
    else     check(e.name, 32'(S_AXI_BRESP), e.exp);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic collect_r();
    sb_t e;
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin ok = 1'b1; break; end
    end
    e = exp_r_q.pop_front();
    if (!ok) fail_timeout(e.name);
    else     check(e.name, S_AXI_RDATA, e.exp);
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic drive_aw(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [31:0] exp, input string name);
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    exp_b_q.push_back('{name, exp});
  endtask

  task automatic drive_ar(input logic [3:0] addr, input logic [31:0] exp, input string name);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    exp_r_q.push_back('{name, exp});
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [31:0] exp, input string name);
    drive_aw(addr, data, strb, exp, name);
    wait_aw(name);
    collect_b();
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    drive_ar(addr, exp, name);
    wait_ar(name);
    collect_r();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1);
  end

  initial begin
    bit ok;

    // wr, addr, data, strb, expected (RDATA or BRESP), led_o after, name
    vecs.push_back('{1'b0, 4'h0, 32'h0,        4'h0, 32'h0,        4'h0, "rst_led_out"});
    vecs.push_back('{1'b0, 4'h4, 32'h0,        4'h0, 32'h0,        4'h0, "rst_btn_state"});
    vecs.push_back('{1'b0, 4'h8, 32'h0,        4'h0, 32'h0,        4'h0, "rst_btn_edge"});
    vecs.push_back('{1'b0, 4'hC, 32'h0,        4'h0, 32'h0,        4'h0, "rst_scratch"});
    vecs.push_back('{1'b1, 4'h0, 32'h0000000A, 4'hF, 32'h0,        4'hA, "wr_led_a"});
    vecs.push_back('{1'b0, 4'h0, 32'h0,        4'h0, 32'h0000000A, 4'hA, "rd_led_a"});
    vecs.push_back('{1'b1, 4'h0, 32'h0,        4'hF, 32'h0,        4'h0, "wr_led_0"});
    vecs.push_back('{1'b1, 4'h0, 32'hFFFFFFFF, 4'h1, 32'h0,        4'hF, "wr_led_strb1"});
    vecs.push_back('{1'b0, 4'h0, 32'h0,        4'h0, 32'h0000000F, 4'hF, "rd_led_masked"});
    vecs.push_back('{1'b1, 4'hC, 32'h12345678, 4'hF, 32'h0,        4'hF, "wr_scratch"});
    vecs.push_back('{1'b1, 4'hC, 32'hAABBCCDD, 4'h5, 32'h0,        4'hF, "wr_scratch_strb5"});
    vecs.push_back('{1'b0, 4'hC, 32'h0,        4'h0, 32'h12BB56DD, 4'hF, "rd_scratch"});
    vecs.push_back('{1'b0, 4'hE, 32'h0,        4'h0, 32'h12BB56DD, 4'hF, "rd_scratch_alias"});
    vecs.push_back('{1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, 32'h0,        4'hF, "wr_btn_state_ro"});
    vecs.push_back('{1'b0, 4'h4, 32'h0,        4'h0, 32'h0,        4'hF, "rd_btn_state_ro"});
    vecs.push_back('{1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 32'h0,        4'hF, "wr_edge_empty"});
    vecs.push_back('{1'b0, 4'h8, 32'h0,        4'h0, 32'h0,        4'hF, "rd_edge_empty"});

    // Reset values of the handshake outputs
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
    check("rst_wready",  32'(S_AXI_WREADY),  32'h0);
    check("rst_bvalid",  32'(S_AXI_BVALID),  32'h0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
    check("rst_rvalid",  32'(S_AXI_RVALID),  32'h0);
    check("rst_rdata",   S_AXI_RDATA,        32'h0);
    check("rst_led_o",   32'(led_o),         32'h0);
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp, vecs[i].name);
      else            do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
      check({vecs[i].name, "_led_o"}, 32'(led_o), 32'(vecs[i].led));
    end

    // Debounce latency: btn[2] steps at E0, btn[1] one cycle later.
    // A read whose handshake lands on E0+19 sees btn[2] (flipped at E0+18) but not btn[1].
    tick();
    btn_i[2] = 1'b1;
    tick();
    btn_i[1] = 1'b1;
    repeat (16) tick();
    drive_ar(4'h4, 32'h4, "lat_btn_state_e18");
    wait_ar("lat_btn_state_e18");
    collect_r();
    do_read(4'h4, 32'h6, "lat_btn_state_both");
    do_read(4'h8, 32'h6, "lat_btn_edge_both");
    do_write(4'h8, 32'h4, 4'hF, 32'h0, "w1c_bit2");
    do_read(4'h8, 32'h2, "edge_after_w1c_bit2");
    do_write(4'h8, 32'h2, 4'hF, 32'h0, "w1c_bit1");
    do_read(4'h8, 32'h0, "edge_after_w1c_bit1");
    btn_i[2] = 1'b0;
    btn_i[1] = 1'b0;
    repeat (25) tick();
    do_read(4'h4, 32'h0, "btn_state_released");
    do_read(4'h8, 32'h0, "no_falling_edge");

    // Set beats a same-cycle W1C: btn[0] rise lands on E0+19, as does the W1C handshake
    btn_i[0] = 1'b1;
    repeat (17) tick();
    drive_aw(4'h8, 32'h1, 4'hF, 32'h0, "w1c_vs_set");
    wait_aw("w1c_vs_set");
    collect_b();
    do_read(4'h8, 32'h1, "edge_set_wins");
    btn_i[0] = 1'b0;
    repeat (25) tick();
    do_write(4'h8, 32'h1, 4'hF, 32'h0, "w1c_bit0");
    do_read(4'h8, 32'h0, "edge_after_w1c_bit0");

    // Bouncing button never settles long enough
    for (int i = 0; i < 20; i++) begin
      btn_i[0] = ~btn_i[0];
      repeat (5) tick();
    end
    repeat (20) tick();
    do_read(4'h4, 32'h0, "bounce_btn_state");
    do_read(4'h8, 32'h0, "bounce_btn_edge");

    // Write and read in the same cycle with stalled responses
    do_write(4'h0, 32'hA, 4'hF, 32'h0, "rw_pre_led");
    drive_aw(4'h0, 32'h5, 4'hF, 32'h0, "rw_bresp");
    drive_ar(4'h0, 32'hA, "rw_old_rdata");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY && S_AXI_ARREADY) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("rw_same_cycle_ready");
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'hC;
    S_AXI_WDATA  = 32'h77;
    exp_b_q.push_back('{"rw_second_bresp", 32'h0});
    exp_r_q.push_back('{"rw_second_rdata", 32'h5});
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      check("rw_hold_bvalid",  32'(S_AXI_BVALID),  32'h1);
      check("rw_hold_rvalid",  32'(S_AXI_RVALID),  32'h1);
      check("rw_hold_rdata",   S_AXI_RDATA,        32'hA);
      check("rw_hold_awready", 32'(S_AXI_AWREADY), 32'h0);
      check("rw_hold_arready", 32'(S_AXI_ARREADY), 32'h0);
    end
    collect_b();
    collect_r();
    wait_aw("rw_second_aw");
    wait_ar("rw_second_ar");
    collect_b();
    collect_r();
    check("rw_led_o", 32'(led_o), 32'h5);
    do_read(4'hC, 32'h77, "rw_scratch");

`ifdef LED_BTN_IRQ_EN
    // Interrupt on an enabled edge, cleared by W1C one cycle later
    do_write(4'hC, 32'h1, 4'hF, 32'h0, "irq_en_wr");
    tick();
    check("irq_idle", 32'(irq_o), 32'h0);
    btn_i[0] = 1'b1;
    repeat (25) tick();
    check("irq_set", 32'(irq_o), 32'h1);
    drive_aw(4'h8, 32'h1, 4'hF, 32'h0, "irq_w1c");
    wait_aw("irq_w1c");
    check("irq_w1c_same_cycle", 32'(irq_o), 32'h1);
    tick();
    check("irq_w1c_next_cycle", 32'(irq_o), 32'h0);
    collect_b();
    btn_i[0] = 1'b0;
    repeat (25) tick();
`endif

    // Reset asserted while a write handshake is pending
    do_write(4'h0, 32'hF, 4'hF, 32'h0, "pre_rst_led");
    do_read(4'h0, 32'hF, "pre_rst_rdata");
    drive_aw(4'h0, 32'h3, 4'hF, 32'h0, "rst_mid_write");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("rst_mid_write_ready");
    void'(exp_b_q.pop_front());
    ARESETN = 1'b0;
    #1;
    check("midrst_awready", 32'(S_AXI_AWREADY), 32'h0);
    check("midrst_wready",  32'(S_AXI_WREADY),  32'h0);
    check("midrst_bvalid",  32'(S_AXI_BVALID),  32'h0);
    check("midrst_arready", 32'(S_AXI_ARREADY), 32'h0);
    check("midrst_rvalid",  32'(S_AXI_RVALID),  32'h0);
    check("midrst_rdata",   S_AXI_RDATA,        32'h0);
    check("midrst_led_o",   32'(led_o),         32'h0);
`ifdef LED_BTN_IRQ_EN
    check("midrst_irq_o",   32'(irq_o),         32'h0);
`endif
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
    do_read(4'h0, 32'h0, "post_rst_led");
    do_read(4'hC, 32'h0, "post_rst_scratch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_btn_axil_regs.md
Name: led_btn_axil_regs

Overview:
AXI4-Lite slave register block that sits directly downstream of the AXI VIP master in the LED/button block design. It decodes four 32-bit registers, drives the board LEDs and samples the push buttons. Button inputs are synchronised and debounced, with sticky rising-edge capture. Software observes buttons by polling or, optionally, by interrupt.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses addr[3:2]
NUM_LEDS, 4, LED outputs (1..32)
NUM_BTNS, 4, button inputs (1..32)
DEBOUNCE_CYCLES, 16, consecutive stable ACLK cycles before a debounced value changes (>=2)

Ports:
ACLK  in  1  single clock domain
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
led_o  out  NUM_LEDS  LED drive = LED_OUT[NUM_LEDS-1:0]
btn_i  in  NUM_BTNS  raw, asynchronous buttons

Behaviour:
- Register map (byte offset):
  - 0x0 LED_OUT: RW.
  - 0x4 BTN_STATE: RO, debounced levels; writes are ignored but still answered OKAY.
  - 0x8 BTN_EDGE: W1C, sticky debounced rising edges.
  - 0xC SCRATCH_IRQEN: RW. Bits [NUM_BTNS-1:0] are IRQ enables when the option is built; otherwise a plain scratch register.
- Register bits at or above NUM_LEDS/NUM_BTNS read 0.
- Reset (ARESETN low, async assert, sync release): all READY/VALID low, RDATA=0, all registers 0, led_o=0, debouncers cleared to 0.
- Write path:
  - Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AWREADY and WREADY assert together for one cycle, only when AWVALID and WVALID are both high. Neither channel is accepted alone.
  - Register update happens on the handshake edge; WSTRB is honoured per byte.
  - Move to W_RESP with BVALID=1, held until BREADY, then return to W_IDLE. One outstanding write maximum.
- Read path:
  - Read FSM states: R_IDLE, R_DATA.
  - In R_IDLE, ARREADY=1 for one cycle when ARVALID is high. RDATA is registered on that edge and RVALID=1 the next cycle (latency 1).
  - RDATA/RVALID stay stable until RREADY; ARREADY stays low while RVALID is high.
- Read and write channels are independent and may complete in the same cycle. A read of a register being written that same cycle returns the old value.
- Debounce, per button:
  - 2-flop synchroniser, then a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets whenever the synchronised input equals the current debounced value; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1 the debounced value flips and the counter clears.
  - Total latency from a clean btn_i step to a BTN_STATE change: 2 + DEBOUNCE_CYCLES cycles.
- Edge capture:
  - A debounced 0->1 sets the BTN_EDGE bit.
  - If a W1C write and a new edge hit the same bit in the same cycle, set wins.
  - Falling edges are not captured.
- Address decode uses only addr[3:2], so aliases wrap every 16 bytes.

Optional Feature:
- Macro: LED_BTN_IRQ_EN.
- Defined:
  - Adds output port irq_o (1 bit).
  - irq_o = registered OR over (BTN_EDGE & SCRATCH_IRQEN[NUM_BTNS-1:0]), one cycle after either operand changes; reset 0.
  - Level-sensitive; deasserts once W1C clears the enabled bits.
- Undefined: no irq_o port; 0xC behaves as a 32-bit scratch register, fully RW.

Decomposition:
- Shared package led_btn_pkg:
  - register offset localparams: LED_OUT_OFS, BTN_STATE_OFS, BTN_EDGE_OFS, SCRATCH_OFS;
  - resp constant AXI_RESP_OKAY;
  - enum typedefs wr_state_t and rd_state_t.
- Sub-module led_btn_debounce: synchroniser plus counter for one button, instantiated NUM_BTNS times in a generate loop; it outputs the debounced level and a one-cycle rise pulse.

Test Plan:
- Write 0x0000000A to 0x0 with WSTRB=0xF -> BRESP=OKAY; led_o=4'hA; read 0x0 returns 0x0000000A.
- Write 0xFFFFFFFF to 0x0 with WSTRB=0x1 after LED_OUT=0 -> read returns 0x0000000F (NUM_LEDS=4 masks upper bits).
- btn_i[2] 0->1, held 20 cycles with DEBOUNCE_CYCLES=16:
  - BTN_STATE=0x4 exactly 18 cycles after the step;
  - BTN_EDGE=0x4;
  - writing 0x4 to 0x8 clears it to 0.
- btn_i[0] toggled every 5 cycles for 100 cycles -> BTN_STATE and BTN_EDGE remain 0.
- Write and read issued in the same cycle with BREADY/RREADY held low 3 cycles -> BVALID/RVALID held stable, no second AWREADY/ARREADY until each response completes.
- With LED_BTN_IRQ_EN defined:
  - write 0x1 to 0xC, debounce btn_i[0] rise -> irq_o=1;
  - W1C 0x1 to 0x8 -> irq_o=0 on the next cycle;
  - assert ARESETN low mid-write -> all outputs 0 immediately.
